// File: rtl/muldiv_seq_if.sv
// Execute-stage handshake and operand bundle for the iterative RV32M multiply/divide unit.
interface muldiv_seq_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, op_a, op_b, flush,
                  input  busy, stall, done, result);
  modport slave  (input  start, funct3, op_a, op_b, flush,
                  output busy, stall, done, result);
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M sequencer: shift-add multiply / restoring divide on operand magnitudes,
// one bit per cycle, with divide special cases resolved at accept time.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0]   ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   ALL1 = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   ONE  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE2 = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   SMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]     LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] p_q, p_d;
  logic [XLEN-1:0]   m_q, m_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_sgn_s, b_sgn_s, a_neg_s, b_neg_s, is_div_s, special_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s, special_res_s, div_val_s, fin_s;
  logic [XLEN:0]     add_s;
  logic [XLEN+1:0]   sub_s;
  logic [2*XLEN-1:0] mul_next_s, div_next_s, p_next_s, prod_s;

  // Operand signedness, magnitudes and divide special cases from the incoming request
  always_comb begin
    a_sgn_s   = (bus.funct3 != 3'b011) && (bus.funct3 != 3'b101) && (bus.funct3 != 3'b111);
    b_sgn_s   = a_sgn_s && (bus.funct3 != 3'b010);
    a_neg_s   = a_sgn_s & bus.op_a[XLEN-1];
    b_neg_s   = b_sgn_s & bus.op_b[XLEN-1];
    a_mag_s   = a_neg_s ? (~bus.op_a + ONE) : bus.op_a;
    b_mag_s   = b_neg_s ? (~bus.op_b + ONE) : bus.op_b;
    is_div_s  = bus.funct3[2];
    special_s = is_div_s && ((bus.op_b == ZERO) ||
                (!bus.funct3[0] && (bus.op_a == SMIN) && (bus.op_b == ALL1)));
    if (bus.op_b == ZERO) begin
      special_res_s = bus.funct3[1] ? bus.op_a : ALL1;
    end else begin
      special_res_s = bus.funct3[1] ? ZERO : bus.op_a;
    end
  end

  // One iteration of either algorithm; p holds {acc/remainder, multiplier/quotient}
  always_comb begin
    add_s      = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});
    mul_next_s = {add_s, p_q[XLEN-1:1]};
    sub_s      = {1'b0, p_q[2*XLEN-1:XLEN-1]} - {2'b00, m_q};
    if (sub_s[XLEN+1]) begin
      div_next_s = {p_q[2*XLEN-2:0], 1'b0};
    end else begin
      div_next_s = {sub_s[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
    end
    p_next_s  = op_q[2] ? div_next_s : mul_next_s;
    prod_s    = neg_q ? (~p_next_s + ONE2) : p_next_s;
    div_val_s = op_q[1] ? p_next_s[2*XLEN-1:XLEN] : p_next_s[XLEN-1:0];
    if (op_q[2]) begin
      fin_s = neg_q ? (~div_val_s + ONE) : div_val_s;
    end else if (op_q[1:0] == 2'b00) begin
      fin_s = prod_s[XLEN-1:0];
    end else begin
      fin_s = prod_s[2*XLEN-1:XLEN];
    end
  end

  // Next-state and register-load decisions
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    m_d      = m_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d  = bus.funct3;
          cnt_d = {CW{1'b0}};
          // Remainder takes the dividend's sign; everything else the XOR of both
          neg_d = (is_div_s && bus.funct3[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
          m_d   = is_div_s ? b_mag_s : a_mag_s;
          p_d   = {ZERO, (is_div_s ? a_mag_s : b_mag_s)};
          if (special_s) begin
            result_d = special_res_s;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          p_d   = p_next_s;
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == LAST) begin
            result_d = fin_s;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      p_q      <= {(2*XLEN){1'b0}};
      m_q      <= ZERO;
      op_q     <= 3'b000;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= ZERO;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      m_q      <= m_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.stall  = ((state_q == S_IDLE) && bus.start && !bus.flush) || (state_q == S_CALC);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: per-cycle comparison against an arithmetic reference model,
// plus literal expectations for results and latencies.
module tb_muldiv_seq;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  muldiv_seq_if #(.XLEN(32)) bus ();
  muldiv_seq #(.XLEN(32)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // RV32M reference results computed with plain 64-bit / 32-bit arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    ia = $signed(a);
    ib = $signed(b);
    r  = 32'h0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (b == 32'h0) ? 32'hFFFFFFFF :
                ((a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(ia / ib));
      3'd5: r = (b == 32'h0) ? 32'hFFFFFFFF : (a / b);
      3'd6: r = (b == 32'h0) ? a :
                ((a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(ia % ib));
      3'd7: r = (b == 32'h0) ? a : (a % b);
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 32'h0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // Cycle-level model: busy/done/result/stall expectations
  bit          m_busy, m_done;
  logic [31:0] m_result, m_pend;
  int          m_left;
  initial begin
    m_busy = 1'b0; m_done = 1'b0; m_result = 32'h0; m_pend = 32'h0; m_left = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 1'b0; m_done = 1'b0; m_result = 32'h0; m_left = 0;
      end
      check("busy",   {31'h0, bus.busy},  {31'h0, m_busy});
      check("done",   {31'h0, bus.done},  {31'h0, m_done});
      check("stall",  {31'h0, bus.stall},
            {31'h0, (!m_busy && bus.start && !bus.flush) || (m_busy && !m_done)});
      check("result", bus.result, m_result);
      if (rst_n) begin
        if (m_done) begin
          m_done = 1'b0;
          m_busy = 1'b0;
        end else if (m_busy) begin
          if (bus.flush) begin
            m_busy = 1'b0;
          end else begin
            m_left--;
            if (m_left == 0) begin
              m_done   = 1'b1;
              m_result = m_pend;
            end
          end
        end else if (bus.start && !bus.flush) begin
          m_busy = 1'b1;
          m_pend = ref_res(bus.funct3, bus.op_a, bus.op_b);
          if (is_special(bus.funct3, bus.op_a, bus.op_b)) begin
            m_done   = 1'b1;
            m_result = m_pend;
          end else begin
            m_left = 32;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    step();
    bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b; bus.flush = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int lat);
    int cyc;
    bit seen;
    cyc = c0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        step();
        bus.start = 1'b0;
        cyc++;
      end
    end
    if (!seen) check("done_timeout", 32'(cyc), 32'd100 - 32'd1);
    lat = cyc;
  endtask

  task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    launch(f, a, b);
    wait_done(0, lat);
    check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    check({nm, "_res"}, bus.result, exp);
  endtask

  typedef struct {
    string       nm;
    logic [2:0]  f;
    logic [31:0] a, b, exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int   lat;

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.funct3 = 3'b000; bus.op_a = 32'h0; bus.op_b = 32'h0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy",   {31'h0, bus.busy}, 32'h0);
    check("rst_done",   {31'h0, bus.done}, 32'h0);
    check("rst_result", bus.result,        32'h0);

    // Model pinned against hand-computed values
    check("model_mul",    ref_res(3'd0, 32'd7, 32'hFFFFFFFD),          32'hFFFFFFEB);
    check("model_mulhsu", ref_res(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF),   32'hFFFFFFFF);
    check("model_rem",    ref_res(3'd6, 32'hFFFFFFF9, 32'd2),          32'hFFFFFFFF);

    vecs.push_back('{"mul",     3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33});
    vecs.push_back('{"mulh",    3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33});
    vecs.push_back('{"mulhu",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
    vecs.push_back('{"mulhsu",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33});
    vecs.push_back('{"div",     3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
    vecs.push_back('{"rem",     3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
    vecs.push_back('{"divu",    3'd5, 32'd100,      32'd7,        32'd14,       33});
    vecs.push_back('{"remu",    3'd7, 32'd100,      32'd7,        32'd2,        33});
    vecs.push_back('{"divu0",   3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{"rem0",    3'd6, 32'd5,        32'd0,        32'd5,        1});
    vecs.push_back('{"rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1});
    vecs.push_back('{"div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    foreach (vecs[i]) do_op(vecs[i].nm, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Flush a DIV in cycle 10, then start MUL 3*4 in cycle 12
    launch(3'd4, 32'd1000, 32'd3);
    for (int i = 1; i <= 9; i++) begin
      step();
      bus.start = 1'b0;
    end
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy",   {31'h0, bus.busy}, 32'h0);
    check("flush_result", bus.result,        32'h80000000);
    launch(3'd0, 32'd3, 32'd4);
    wait_done(0, lat);
    check("flush_mul_cycle", 32'(12 + lat), 32'd45);
    check("flush_mul_res",   bus.result,    32'd12);

    // Reset in cycle 5 of a MUL
    launch(3'd0, 32'd9, 32'd9);
    for (int i = 1; i <= 5; i++) begin
      step();
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("arst_busy",   {31'h0, bus.busy}, 32'h0);
    check("arst_done",   {31'h0, bus.done}, 32'h0);
    check("arst_result", bus.result,        32'h0);
    step();
    rst_n = 1'b1;

    // Back-to-back starts: the second one arrives while busy and is dropped
    launch(3'd0, 32'd5, 32'd6);
    step();
    bus.start = 1'b1; bus.op_a = 32'd2; bus.op_b = 32'd2;
    wait_done(1, lat);
    check("b2b_lat", 32'(lat), 32'd33);
    check("b2b_res", bus.result, 32'd30);
    step();
    bus.start = 1'b0;
    @(negedge clk);
    check("b2b_idle", {31'h0, bus.busy}, 32'h0);

    // A few mixed operands checked through the model
    do_op("mix_mulh", 3'd1, 32'h12345678, 32'hFEDCBA98, ref_res(3'd1, 32'h12345678, 32'hFEDCBA98), 33);
    do_op("mix_div",  3'd4, 32'h7FFFFFFF, 32'hFFFFFFF0, ref_res(3'd4, 32'h7FFFFFFF, 32'hFFFFFFF0), 33);
    do_op("mix_rem",  3'd6, 32'h87654321, 32'd1234,     ref_res(3'd6, 32'h87654321, 32'd1234),     33);
    do_op("mix_remu", 3'd7, 32'hDEADBEEF, 32'h00010001, ref_res(3'd7, 32'hDEADBEEF, 32'h00010001), 33);

    step();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
